// File: rtl/montgomery_encoder.sv
// Montgomery-domain entry converter: result = (x * 2^k) mod m, where k is the
// bit length of m. Radix-2 restoring remainder over the dividend {x, k zeros},
// one dividend bit per clock, no multipliers.
module montgomery_encoder #(
  parameter int WIDTH = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH-1:0] result_o,
  output logic             valid_o,
  output logic             err_o,
  output logic             busy_o
);

  // k ranges 0..WIDTH; the iteration counter ranges 0..2*WIDTH
  localparam int KW = $clog2(WIDTH + 1);
  localparam int CW = $clog2(2 * WIDTH + 1);

  localparam logic [WIDTH-1:0] M_MIN   = WIDTH'(3);
  localparam logic [CW-1:0]    CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] x_sh;       // operand, shifted left once per iteration
  logic [WIDTH-1:0] m_r;
  logic [KW-1:0]    k_r;
  logic [WIDTH:0]   rem_r;      // partial remainder, always < m
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] result_r;
  logic             valid_r;
  logic             err_r;

  logic             m_bad;
  logic             dividend_bit;
  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   rem_next;
  logic [CW-1:0]    last_cnt;
  logic             last_iter;

  // Bit length of a value: index of the highest set bit plus one
  function automatic logic [KW-1:0] bit_len(input logic [WIDTH-1:0] v);
    logic [KW-1:0] len;
    len = {KW{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) begin
        len = KW'(i + 1);
      end
    end
    return len;
  endfunction

  // Remainder step and iteration bookkeeping. Once the WIDTH operand bits
  // are shifted out, zeros fill in, which supplies the k trailing zero bits.
  always_comb begin
    m_bad        = ~m_i[0] | (m_i < M_MIN);
    dividend_bit = x_sh[WIDTH-1];
    m_ext        = {1'b0, m_r};
    trial        = (rem_r << 1'b1) | {{WIDTH{1'b0}}, dividend_bit};
    if (trial >= m_ext) begin
      rem_next = trial - m_ext;
    end else begin
      rem_next = trial;
    end
    last_cnt  = CW'(WIDTH) + CW'(k_r) - CNT_ONE;
    last_iter = (cnt_r == last_cnt);
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_i) begin
          state_next = m_bad ? DONE : CALC;
        end else begin
          state_next = IDLE;
        end
      end
      CALC: begin
        if (last_iter) begin
          state_next = DONE;
        end else begin
          state_next = CALC;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_sh     <= {WIDTH{1'b0}};
      m_r      <= {WIDTH{1'b0}};
      k_r      <= {KW{1'b0}};
      rem_r    <= {(WIDTH+1){1'b0}};
      cnt_r    <= {CW{1'b0}};
      result_r <= {WIDTH{1'b0}};
      valid_r  <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            x_sh  <= x_i;
            m_r   <= m_i;
            k_r   <= bit_len(m_i);
            rem_r <= {(WIDTH+1){1'b0}};
            cnt_r <= {CW{1'b0}};
            if (m_bad) begin
              // Illegal modulus completes at once with an error-qualified pulse
              result_r <= {WIDTH{1'b0}};
              valid_r  <= 1'b1;
              err_r    <= 1'b1;
            end else begin
              valid_r  <= 1'b0;
              err_r    <= 1'b0;
            end
          end else begin
            valid_r <= 1'b0;
            err_r   <= 1'b0;
          end
        end
        CALC: begin
          x_sh  <= x_sh << 1'b1;
          rem_r <= rem_next;
          cnt_r <= cnt_r + CNT_ONE;
          if (last_iter) begin
            result_r <= rem_next[WIDTH-1:0];
            valid_r  <= 1'b1;
            err_r    <= 1'b0;
          end else begin
            valid_r  <= 1'b0;
            err_r    <= 1'b0;
          end
        end
        DONE: begin
          valid_r <= 1'b0;
          err_r   <= 1'b0;
        end
        default: begin
          valid_r <= 1'b0;
          err_r   <= 1'b0;
        end
      endcase
    end
  end

  assign result_o = result_r;
  assign valid_o  = valid_r;
  assign err_o    = err_r;
  assign busy_o   = (state != IDLE);

endmodule

// File: tb/tb_montgomery_encoder.sv
// Randomized self-checking bench for montgomery_encoder against an
// arithmetic reference ((x << k) % m on 128-bit values).
module tb_montgomery_encoder;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_ni;
  logic         start_i;
  logic [W-1:0] x_i;
  logic [W-1:0] m_i;
  logic [W-1:0] result_o;
  logic         valid_o;
  logic         err_o;
  logic         busy_o;

  int n_cmp = 0;
  int n_bad = 0;

  montgomery_encoder #(.WIDTH(W)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
    .start_i  (start_i),
    .x_i      (x_i),
    .m_i      (m_i),
    .result_o (result_o),
    .valid_o  (valid_o),
    .err_o    (err_o),
    .busy_o   (busy_o)
  );

  always #5 clk = ~clk;

  // Reference: latency counts clock edges after the accepting edge until
  // valid_o is seen (0 means valid_o is high in the cycle right after it).
  function automatic void model(input logic [63:0] xv, input logic [63:0] mv,
                                output logic [63:0] res, output logic e, output int lat);
    int k;
    logic [127:0] prod;
    e = (mv[0] == 1'b0) || (mv < 64'd3);
    k = 0;
    for (int i = 0; i < 64; i++) if (mv[i]) k = i + 1;
    if (e) begin
      res = 64'd0;
      lat = 0;
    end else begin
      prod = {64'd0, xv} << k;
      prod = prod % {64'd0, mv};
      res  = prod[63:0];
      lat  = W + k;
    end
  endfunction

  // Runs one conversion from IDLE (called #1 after a rising edge) and
  // reports what was observed; returns #1 after the edge that ends DONE.
  task automatic do_conv(input logic [63:0] xv, input logic [63:0] mv,
                         output logic [63:0] res, output logic e, output int lat,
                         output logic busy_done, output logic valid_after,
                         output logic busy_after, output logic tmo);
    start_i = 1'b1;
    x_i = xv;
    m_i = mv;
    @(posedge clk); #1;
    start_i = 1'b0;
    x_i = {$urandom, $urandom};
    m_i = {$urandom, $urandom};
    lat = 0;
    while (!valid_o && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    tmo       = !valid_o;
    res       = result_o;
    e         = err_o;
    busy_done = busy_o;
    @(posedge clk); #1;
    valid_after = valid_o;
    busy_after  = busy_o;
  endtask

  task automatic test_reset;
    rst_ni = 1'b0; start_i = 1'b0; x_i = 64'd0; m_i = 64'd0;
    @(posedge clk); @(posedge clk); #1;
    n_cmp++; if (result_o !== 64'd0) begin n_bad++; $display("FAIL reset_result: got %0h want 0", result_o); end
    n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    rst_ni = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    logic [63:0] dx [5];
    logic [63:0] dm [5];
    logic [63:0] dexp [5];
    int dlat [5];
    logic [63:0] res; logic e, bd, va, ba, tmo; int lat;
    dx[0] = 64'd3;  dm[0] = 64'd17; dexp[0] = 64'd11; dlat[0] = 69;
    dx[1] = 64'd100; dm[1] = 64'd17; dexp[1] = 64'd4; dlat[1] = 69;
    dx[2] = 64'd1;  dm[2] = 64'h1FFF_FFFF_FFFF_FFFF; dexp[2] = 64'd1; dlat[2] = 125;
    dx[3] = 64'd0;  dm[3] = 64'h1FFF_FFFF_FFFF_FFFF; dexp[3] = 64'd0; dlat[3] = 125;
    dx[4] = 64'hFFFF_FFFF_FFFF_FFFF; dm[4] = 64'hFFFF_FFFF_FFFF_FFC5; dexp[4] = 64'd3422; dlat[4] = 128;
    for (int i = 0; i < 5; i++) begin
      do_conv(dx[i], dm[i], res, e, lat, bd, va, ba, tmo);
      n_cmp++; if (tmo) begin n_bad++; $display("FAIL dir%0d_timeout: no valid_o within 400 cycles", i); end
      n_cmp++; if (res !== dexp[i]) begin n_bad++; $display("FAIL dir%0d_result: got %0d want %0d", i, res, dexp[i]); end
      n_cmp++; if (lat != dlat[i]) begin n_bad++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, dlat[i]); end
      n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL dir%0d_err: got %b want 0", i, e); end
      n_cmp++; if (bd !== 1'b1) begin n_bad++; $display("FAIL dir%0d_busy_done: got %b want 1", i, bd); end
      n_cmp++; if (va !== 1'b0 || ba !== 1'b0) begin n_bad++; $display("FAIL dir%0d_pulse: valid %b busy %b want 0 0", i, va, ba); end
    end
  endtask

  task automatic test_illegal;
    logic [63:0] ms [5];
    logic [63:0] res; logic e, bd, va, ba, tmo; int lat;
    ms[0] = 64'd16; ms[1] = 64'd1; ms[2] = 64'd0; ms[3] = 64'd2;
    ms[4] = {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FFFE;
    for (int i = 0; i < 5; i++) begin
      do_conv({$urandom, $urandom}, ms[i], res, e, lat, bd, va, ba, tmo);
      n_cmp++; if (tmo) begin n_bad++; $display("FAIL ill%0d_timeout: no valid_o", i); end
      n_cmp++; if (lat != 0) begin n_bad++; $display("FAIL ill%0d_latency: got %0d want 0", i, lat); end
      n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL ill%0d_err: got %b want 1", i, e); end
      n_cmp++; if (res !== 64'd0) begin n_bad++; $display("FAIL ill%0d_result: got %0h want 0", i, res); end
      n_cmp++; if (va !== 1'b0 || ba !== 1'b0) begin n_bad++; $display("FAIL ill%0d_after: valid %b busy %b want 0 0", i, va, ba); end
    end
  endtask

  task automatic test_random;
    logic [63:0] xv, mv, eres, res; logic eerr, e, bd, va, ba, tmo; int elat, lat, kk;
    for (int i = 0; i < 24; i++) begin
      kk = $urandom_range(64, 2);
      mv = {$urandom, $urandom};
      mv = mv >> (64 - kk);
      mv[kk-1] = 1'b1;
      mv[0] = 1'b1;
      xv = {$urandom, $urandom};
      case (i % 4)
        0: xv = 64'd0;
        1: xv = xv % mv;
        default: ;
      endcase
      model(xv, mv, eres, eerr, elat);
      do_conv(xv, mv, res, e, lat, bd, va, ba, tmo);
      n_cmp++; if (tmo) begin n_bad++; $display("FAIL rnd%0d_timeout: no valid_o", i); end
      n_cmp++; if (res !== eres) begin n_bad++; $display("FAIL rnd%0d_result: x %0h m %0h got %0h want %0h", i, xv, mv, res, eres); end
      n_cmp++; if (lat != elat) begin n_bad++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, elat); end
      n_cmp++; if (e !== eerr) begin n_bad++; $display("FAIL rnd%0d_err: got %b want %b", i, e, eerr); end
      n_cmp++; if (res >= mv) begin n_bad++; $display("FAIL rnd%0d_range: got %0h not below %0h", i, res, mv); end
      n_cmp++; if (va !== 1'b0) begin n_bad++; $display("FAIL rnd%0d_pulse: got %b want 0", i, va); end
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    start_i = 1'b1; x_i = 64'd3; m_i = 64'd17;
    @(posedge clk); #1;
    start_i = 1'b0;
    lat = 0;
    // stray starts with other operands during CALC must be ignored
    while (!valid_o && lat < 400) begin
      start_i = (lat == 10 || lat == 40 || lat == 68);
      x_i = {$urandom, $urandom};
      m_i = {$urandom, $urandom} | 64'd1;
      @(posedge clk); #1;
      lat++;
    end
    n_cmp++; if (!valid_o) begin n_bad++; $display("FAIL b2b_timeout: no valid_o"); end
    n_cmp++; if (result_o !== 64'd11) begin n_bad++; $display("FAIL b2b_ignore_result: got %0d want 11", result_o); end
    n_cmp++; if (lat != 69) begin n_bad++; $display("FAIL b2b_ignore_latency: got %0d want 69", lat); end
    // start held from the DONE cycle is taken only once back in IDLE
    start_i = 1'b1; x_i = 64'd100; m_i = 64'd17;
    @(posedge clk); #1;
    n_cmp++; if (valid_o !== 1'b0 || busy_o !== 1'b0) begin n_bad++; $display("FAIL b2b_idle: valid %b busy %b want 0 0", valid_o, busy_o); end
    @(posedge clk); #1;
    start_i = 1'b0;
    n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL b2b_accept_busy: got %b want 1", busy_o); end
    lat = 0;
    while (!valid_o && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    n_cmp++; if (result_o !== 64'd4) begin n_bad++; $display("FAIL b2b_result: got %0d want 4", result_o); end
    n_cmp++; if (lat != 69) begin n_bad++; $display("FAIL b2b_latency: got %0d want 69", lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_abort;
    logic [63:0] res; logic e, bd, va, ba, tmo, seen; int lat;
    start_i = 1'b1; x_i = 64'd3; m_i = 64'd17;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst_ni = 1'b0;
    #1;
    n_cmp++; if (result_o !== 64'd0) begin n_bad++; $display("FAIL abort_result: got %0h want 0", result_o); end
    n_cmp++; if (valid_o !== 1'b0 || busy_o !== 1'b0 || err_o !== 1'b0) begin
      n_bad++; $display("FAIL abort_flags: valid %b busy %b err %b want 0 0 0", valid_o, busy_o, err_o); end
    @(posedge clk); #1;
    rst_ni = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (valid_o || busy_o) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL abort_no_valid: activity after reset got %b want 0", seen); end
    do_conv(64'd3, 64'd17, res, e, lat, bd, va, ba, tmo);
    n_cmp++; if (res !== 64'd11 || tmo) begin n_bad++; $display("FAIL abort_rerun_result: got %0d want 11", res); end
    n_cmp++; if (lat != 69) begin n_bad++; $display("FAIL abort_rerun_latency: got %0d want 69", lat); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_illegal();
    test_random();
    test_back_to_back();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
